sn74123: RTL and testbench

SN74123 -- requirements
Module: sn74123

---
 rtl/sn74123_if.sv | 24 ++
 rtl/sn74123.sv | 105 ++++++++++
 tb/tb_sn74123.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sn74123_if.sv
// Pin bundle for the dual retriggerable monostable: trigger/clear inputs and
// pulse outputs of both channels.
interface sn74123_if;
  logic a1_n;
  logic b1;
  logic clr1_n;
  logic q1;
  logic q1_n;
  logic a2_n;
  logic b2;
  logic clr2_n;
  logic q2;
  logic q2_n;

  modport master (
    output a1_n, b1, clr1_n, a2_n, b2, clr2_n,
    input  q1, q1_n, q2, q2_n
  );

  modport slave (
    input  a1_n, b1, clr1_n, a2_n, b2, clr2_n,
    output q1, q1_n, q2, q2_n
  );
endinterface

// File: rtl/sn74123.sv
// Clocked model of the SN74123 dual retriggerable monostable multivibrator.
// Edges are detected against registered previous samples; pulse width is counted in mclk cycles.
module sn74123_chan #(
  parameter int CW    = 16,
  parameter int WIDTH = 10
) (
  input  logic mclk,
  input  logic reset,
  input  logic a_n,
  input  logic b,
  input  logic clr_n,
  output logic q,
  output logic q_n
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          old_a_n;
  logic          old_b;
  logic          old_clr_n;
  logic          trigger;

  localparam logic [CW-1:0] RELOAD = CW'(WIDTH - 1);

  // Old-sample reset values make levels at release look edge-free unless they
  // actually differ from an idle input set.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      q         <= 1'b0;
      q_n       <= 1'b1;
      old_a_n   <= 1'b1;
      old_b     <= 1'b0;
      old_clr_n <= 1'b1;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      q         <= (state_nxt == ACTIVE);
      q_n       <= (state_nxt != ACTIVE);
      old_a_n   <= a_n;
      old_b     <= b;
      old_clr_n <= clr_n;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    trigger   = clr_n && ((old_a_n && !a_n && b) ||
                          (!old_b && b && !a_n) ||
                          (!old_clr_n && clr_n && !a_n && b));
    // Clear dominates a trigger; a trigger reloads even mid-pulse so retriggers extend seamlessly.
    if (!clr_n) begin
      state_nxt = IDLE;
      count_nxt = '0;
    end else if (trigger) begin
      state_nxt = ACTIVE;
      count_nxt = RELOAD;
    end else if (state == ACTIVE) begin
      if (count != '0) begin
        count_nxt = count - CW'(1);
      end else begin
        state_nxt = IDLE;
      end
    end
  end

endmodule

module sn74123 #(
  parameter int CW     = 16,
  parameter int WIDTH1 = 10,
  parameter int WIDTH2 = 10
) (
  input  logic        mclk,
  input  logic        reset,
  sn74123_if.slave    bus
);

  sn74123_chan #(.CW(CW), .WIDTH(WIDTH1)) u_chan1 (
    .mclk  (mclk),
    .reset (reset),
    .a_n   (bus.a1_n),
    .b     (bus.b1),
    .clr_n (bus.clr1_n),
    .q     (bus.q1),
    .q_n   (bus.q1_n)
  );

  sn74123_chan #(.CW(CW), .WIDTH(WIDTH2)) u_chan2 (
    .mclk  (mclk),
    .reset (reset),
    .a_n   (bus.a2_n),
    .b     (bus.b2),
    .clr_n (bus.clr2_n),
    .q     (bus.q2),
    .q_n   (bus.q2_n)
  );

endmodule

// File: tb/tb_sn74123.sv
// Directed bench for sn74123: two instances with different pulse widths cover
// single pulses, retrigger, clear, reset and channel independence.
module tb_sn74123;

  logic mclk;
  logic reset;
  int   checks;
  int   errors;

  sn74123_if bus_a ();
  sn74123_if bus_b ();

  sn74123 #(.CW(16), .WIDTH1(5), .WIDTH2(1)) dut_a (
    .mclk  (mclk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  sn74123 #(.CW(16), .WIDTH1(3), .WIDTH2(7)) dut_b (
    .mclk  (mclk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Outputs are observed 1 time unit after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.a1_n = 1'b1; bus_a.b1 = 1'b0; bus_a.clr1_n = 1'b1;
    bus_a.a2_n = 1'b1; bus_a.b2 = 1'b0; bus_a.clr2_n = 1'b1;
    bus_b.a1_n = 1'b1; bus_b.b1 = 1'b0; bus_b.clr1_n = 1'b1;
    bus_b.a2_n = 1'b1; bus_b.b2 = 1'b0; bus_b.clr2_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #1;
    checks++;
    if ({bus_a.q1, bus_a.q1_n, bus_a.q2, bus_a.q2_n} !== 4'b0101) begin
      errors++;
      $display("[TB] FAIL reset_a actual=%b required=0101",
               {bus_a.q1, bus_a.q1_n, bus_a.q2, bus_a.q2_n});
    end
    checks++;
    if ({bus_b.q1, bus_b.q1_n, bus_b.q2, bus_b.q2_n} !== 4'b0101) begin
      errors++;
      $display("[TB] FAIL reset_b actual=%b required=0101",
               {bus_b.q1, bus_b.q1_n, bus_b.q2, bus_b.q2_n});
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({bus_a.q1, bus_a.q1_n} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL reset_release q1/q1_n actual=%b required=01", {bus_a.q1, bus_a.q1_n});
    end
  endtask

  // Width 5 pulse from an a1_n fall, then inputs held at trigger levels for 20 cycles.
  task automatic test_single_pulse();
    logic exp;
    bus_a.b1 = 1'b1;
    tick();
    tick();
    checks++;
    if (bus_a.q1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b_rise_with_a_high q1 actual=%b required=0", bus_a.q1);
    end
    bus_a.a1_n = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp = (i <= 5);
      checks++;
      if ({bus_a.q1, bus_a.q1_n} !== {exp, ~exp}) begin
        errors++;
        $display("[TB] FAIL single_pulse cycle %0d q1/q1_n actual=%b required=%b",
                 i, {bus_a.q1, bus_a.q1_n}, {exp, ~exp});
      end
    end
    bus_a.a1_n = 1'b1;
    bus_a.b1   = 1'b0;
    tick();
    tick();
  endtask

  // b1 rises, then rises again three cycles later; the pulse stretches without a gap.
  task automatic test_retrigger();
    logic exp;
    bus_a.a1_n = 1'b0;
    tick();
    checks++;
    if (bus_a.q1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL a_fall_with_b_low q1 actual=%b required=0", bus_a.q1);
    end
    bus_a.b1 = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      exp = (i <= 8);
      checks++;
      if ({bus_a.q1, bus_a.q1_n} !== {exp, ~exp}) begin
        errors++;
        $display("[TB] FAIL retrigger cycle %0d q1/q1_n actual=%b required=%b",
                 i, {bus_a.q1, bus_a.q1_n}, {exp, ~exp});
      end
      if (i == 2) bus_a.b1 = 1'b0;
      if (i == 3) bus_a.b1 = 1'b1;
    end
    bus_a.a1_n = 1'b1;
    bus_a.b1   = 1'b0;
    tick();
    tick();
  endtask

  // Clear cuts a pulse short; its rising edge with a1_n=0, b1=1 fires a fresh pulse.
  task automatic test_clear();
    logic exp;
    bus_a.b1 = 1'b1;
    tick();
    bus_a.a1_n = 1'b0;
    tick();
    tick();
    checks++;
    if (bus_a.q1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clear_setup q1 actual=%b required=1", bus_a.q1);
    end
    bus_a.clr1_n = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      exp = (i >= 3) && (i <= 7);
      checks++;
      if ({bus_a.q1, bus_a.q1_n} !== {exp, ~exp}) begin
        errors++;
        $display("[TB] FAIL clear cycle %0d q1/q1_n actual=%b required=%b",
                 i, {bus_a.q1, bus_a.q1_n}, {exp, ~exp});
      end
      if (i == 2) bus_a.clr1_n = 1'b1;
    end
    bus_a.a1_n = 1'b1;
    bus_a.b1   = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_pulse();
    bus_a.b1 = 1'b1;
    tick();
    bus_a.a1_n = 1'b0;
    tick();
    tick();
    checks++;
    if (bus_a.q1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_reset_setup q1 actual=%b required=1", bus_a.q1);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus_a.q1, bus_a.q1_n} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL async_reset q1/q1_n actual=%b required=01", {bus_a.q1, bus_a.q1_n});
    end
    bus_a.a1_n = 1'b1;
    bus_a.b1   = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if ({bus_a.q1, bus_a.q1_n} !== 2'b01) begin
        errors++;
        $display("[TB] FAIL after_reset cycle %0d q1/q1_n actual=%b required=01",
                 i, {bus_a.q1, bus_a.q1_n});
      end
    end
  endtask

  // Width 3 and width 7 channels fired on the same edge.
  task automatic test_independence();
    logic e1;
    logic e2;
    bus_b.b1 = 1'b1;
    bus_b.b2 = 1'b1;
    tick();
    bus_b.a1_n = 1'b0;
    bus_b.a2_n = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      e1 = (i <= 3);
      e2 = (i <= 7);
      checks++;
      if ({bus_b.q1, bus_b.q1_n, bus_b.q2, bus_b.q2_n} !== {e1, ~e1, e2, ~e2}) begin
        errors++;
        $display("[TB] FAIL independence cycle %0d q1,q1_n,q2,q2_n actual=%b required=%b",
                 i, {bus_b.q1, bus_b.q1_n, bus_b.q2, bus_b.q2_n}, {e1, ~e1, e2, ~e2});
      end
    end
    bus_b.a1_n = 1'b1; bus_b.b1 = 1'b0;
    bus_b.a2_n = 1'b1; bus_b.b2 = 1'b0;
    tick();
  endtask

  // Width 1: single-cycle pulses from an a2_n toggle on every other edge.
  task automatic test_width_one();
    logic exp;
    bus_a.b2 = 1'b1;
    tick();
    for (int i = 1; i <= 6; i++) begin
      bus_a.a2_n = (i % 2 == 1) ? 1'b0 : 1'b1;
      tick();
      exp = (i % 2 == 1);
      checks++;
      if ({bus_a.q2, bus_a.q2_n} !== {exp, ~exp}) begin
        errors++;
        $display("[TB] FAIL width_one cycle %0d q2/q2_n actual=%b required=%b",
                 i, {bus_a.q2, bus_a.q2_n}, {exp, ~exp});
      end
    end
    tick();
    checks++;
    if (bus_a.q2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL width_one_idle q2 actual=%b required=0", bus_a.q2);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_pulse();
    test_retrigger();
    test_clear();
    test_reset_mid_pulse();
    test_independence();
    test_width_one();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
